id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode/execute pipeline register feeding the ALU. Accepts a fetched instruction
//  with its register-file read data. Decodes the 4-bit ALUSel (0 add, 1 sub, 2 sll,
//  3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and) and builds operands A/B, with
//  forwarding from the ALU result. Registers everything for one cycle behind a
//  valid/ready handshake.
//  Supports RV32I OP, OP-IMM, LUI and AUIPC. All other opcodes are flagged illegal.
// PARAMETERS
//  WIDTH  32  datapath width of pc, operands and ALU result
// PORTS
//  clk            in   1      single clock, all state on posedge
//  rst            in   1      synchronous reset, active-high
//  in_valid       in   1      upstream holds a valid instr/pc/rs data
//  in_ready       out  1      stage can accept this cycle
//  in_instr       in   32     instruction word
//  in_pc          in   WIDTH  instruction address
//  rs1_data       in   WIDTH  regfile read port 1 (addr = instr[19:15])
//  rs2_data       in   WIDTH  regfile read port 2 (addr = instr[24:20])
//  ex_wr          in   1      ALU-stage result will be written back
//  ex_rd          in   5      ALU-stage destination register
//  ex_result      in   WIDTH  ALU-stage result (alu_out)
//  flush          in   1      squash held and incoming instruction
//  out_valid      out  1      registered outputs valid
//  out_ready      in   1      downstream (ALU stage) accepts
//  out_alusel     out  4      ALUSel to ALU
//  out_a, out_b   out  WIDTH  ALU in_a / in_b
//  out_rd         out  5      destination register
//  out_reg_write  out  1      result must be written back
//  out_illegal    out  1      undecodable instruction (trap upstream of retire)
//  out_pc         out  WIDTH  pc of held instruction
// BEHAVIOUR
//  - Reset: out_valid=0. All other registered outputs are 0. in_ready=1 the cycle after reset.
//  - in_ready = !out_valid || out_ready (combinational, 1-entry). Accept = in_valid && in_ready.
//  - Latency 1 cycle: on accept, decoded fields are registered and out_valid=1 on the next edge.
//    If out_valid && !out_ready, all out_* hold stable.
//  - out_valid clears on (out_valid && out_ready && !accept).
//  - flush (priority over accept): out_valid<=0 next edge. A same-cycle accept is dropped.
//    A flush while out_valid=0 has no effect.
//  - Forwarding applied to rs1/rs2 before latching: if ex_wr && ex_rd!=0 && ex_rd==rsN,
//    use ex_result, else rsN_data. Register x0 is never forwarded.
//  - OP (0110011), funct7 0x00: f3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor,
//    101 srl, 110 or, 111 and.
//    funct7 0x20: only f3 000 (sub) and 101 (sra) are legal.
//    a=rs1', b=rs2'.
//  - OP-IMM (0010011): same map with b = sign-extended I-immediate. There is no subi.
//    For f3 001/101, b = zero-extended shamt instr[24:20]. funct7 must be 0x00,
//    or 0x20 for srai only.
//  - LUI (0110111): alusel add, a=0, b={instr[31:12],12'b0} sign-extended to WIDTH.
//    AUIPC (0010111): alusel add, a=pc, b=U-imm.
//  - Illegal (any other opcode or funct7): out_illegal=1, alusel=0, a=b=0,
//    reg_write=0. out_valid still asserted so the trap propagates.
//  - out_reg_write = legal && rd!=0.
//  - Reset asserted mid-stall: outputs drop to reset values on that edge. The held instr is lost.
// STRUCTURE
//  - Shared package alu_pkg: ALUSel localparams (ALU_ADD..ALU_AND = 0..9),
//    opcode localparams (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC), funct7 constants.
//    The ALU uses the same package.
//  - One sub-module: imm_gen (combinational I/U immediate and shamt extraction,
//    sign-extended to WIDTH).
//  - Decode and forwarding are combinational in this module; one output register bank.
// TESTING
//  - Reset: rst=1 for 2 clk -> out_valid=0, all out_* =0. in_ready=1 after release.
//  - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1,
//    alusel=0, a=5, b=7, rd=3, reg_write=1.
//  - addi x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, alusel=0.
//    srai x5,x5,3 (0x4032D293) -> alusel=7, b=3.
//  - Forwarding: ex_wr=1, ex_rd=1, ex_result=0x100 with sub x4,x1,x2 ->
//    a=0x100, alusel=1. Same with ex_rd=0 -> a=rs1_data.
//  - Backpressure: out_ready=0 for 3 cycles -> in_ready=0, outputs stable.
//    Second instr is accepted the cycle out_ready=1.
//  - flush with in_valid=1 -> out_valid=0 next cycle.
//    Opcode 0x7F -> out_illegal=1, reg_write=0, alusel=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Shared ALU select codes, RV32I opcode/funct7 constants and operand   |
// | source types used by the decode stage and the ALU.                   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_pkg;

  // ALUSel encoding understood by the ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Supported major opcodes
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // funct7 values: base encoding and the sub/sra alternate
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Operand source selects produced by decode
  typedef enum logic [1:0] {
    A_ZERO,
    A_RS1,
    A_PC
  } a_src_e;

  typedef enum logic [2:0] {
    B_ZERO,
    B_RS2,
    B_IMM_I,
    B_SHAMT,
    B_IMM_U
  } b_src_e;

  // funct3 -> ALUSel; alt selects sub (f3=000) or sra (f3=101)
  function automatic logic [3:0] f3_to_alusel(input logic [2:0] f3, input logic alt);
    logic [3:0] sel;
    sel = ALU_ADD;
    case (f3)
      3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : imm_gen                                                    |
// | Combinational I-type / U-type immediate and shift-amount extraction, |
// | each extended to WIDTH bits.                                         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module imm_gen #(
  parameter int WIDTH = 32
) (
  input  logic [19:0]      instr_hi,  // instruction bits [31:12]
  output logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] imm_u,
  output logic [WIDTH-1:0] shamt
);

  // I-imm lives in instr[31:20]; U-imm is instr[31:12] shifted up by 12
  assign imm_i = WIDTH'($signed(instr_hi[19:8]));
  assign imm_u = WIDTH'($signed({instr_hi, 12'b0}));
  // Shift amount is instr[24:20], always zero-extended
  assign shamt = WIDTH'(instr_hi[12:8]);

endmodule : imm_gen
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : id_ex_stage                                                |
// | Decode/execute pipeline register: decodes RV32I OP/OP-IMM/LUI/AUIPC  |
// | into ALUSel and operands with ALU-result forwarding, held in a       |
// | single-entry valid/ready register.                                   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             ex_wr,
  input  logic [4:0]       ex_rd,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alusel,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [WIDTH-1:0] out_pc
);
  import alu_pkg::*;

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [6:0]       funct7;
  logic             accept;
  logic             fwd_rs1;
  logic             fwd_rs2;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] shamt;
  logic             legal;
  logic [3:0]       dec_alusel;
  a_src_e           a_src;
  b_src_e           b_src;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign funct7   = in_instr[31:25];

  // Single entry: a new instruction fits when empty or being drained
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // x0 is hard-wired zero, so a pending write to it is never forwarded
  assign fwd_rs1 = ex_wr && (ex_rd != 5'd0) && (ex_rd == rs1_addr);
  assign fwd_rs2 = ex_wr && (ex_rd != 5'd0) && (ex_rd == rs2_addr);
  assign rs1_val = fwd_rs1 ? ex_result : rs1_data;
  assign rs2_val = fwd_rs2 ? ex_result : rs2_data;

  imm_gen #(
    .WIDTH(WIDTH)
  ) u_imm_gen (
    .instr_hi(in_instr[31:12]),
    .imm_i   (imm_i),
    .imm_u   (imm_u),
    .shamt   (shamt)
  );

  // Decode opcode/funct fields into ALUSel and operand sources; illegal
  // encodings fall through with zero operands and ALU_ADD
  always_comb begin
    legal      = 1'b0;
    dec_alusel = ALU_ADD;
    a_src      = A_ZERO;
    b_src      = B_ZERO;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal      = 1'b1;
          dec_alusel = f3_to_alusel(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal      = 1'b1;
          dec_alusel = f3_to_alusel(funct3, 1'b1);
        end
        if (legal) begin
          a_src = A_RS1;
          b_src = B_RS2;
        end
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001) begin
          legal      = (funct7 == F7_BASE);
          dec_alusel = ALU_SLL;
          b_src      = B_SHAMT;
        end else if (funct3 == 3'b101) begin
          legal      = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_alusel = f3_to_alusel(funct3, funct7 == F7_ALT);
          b_src      = B_SHAMT;
        end else begin
          // funct7 is part of the immediate here; there is no subi
          legal      = 1'b1;
          dec_alusel = f3_to_alusel(funct3, 1'b0);
          b_src      = B_IMM_I;
        end
        a_src = A_RS1;
        if (!legal) begin
          dec_alusel = ALU_ADD;
          a_src      = A_ZERO;
          b_src      = B_ZERO;
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        a_src = A_ZERO;
        b_src = B_IMM_U;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a_src = A_PC;
        b_src = B_IMM_U;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Operand muxes driven by the decoded sources
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (a_src)
      A_RS1:   op_a = rs1_val;
      A_PC:    op_a = in_pc;
      default: op_a = '0;
    endcase
    case (b_src)
      B_RS2:   op_b = rs2_val;
      B_IMM_I: op_b = imm_i;
      B_SHAMT: op_b = shamt;
      B_IMM_U: op_b = imm_u;
      default: op_b = '0;
    endcase
  end

  // Output register bank: flush beats accept, accept beats drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_alusel    <= ALU_ADD;
      out_a         <= '0;
      out_b         <= '0;
      out_rd        <= 5'd0;
      out_reg_write <= 1'b0;
      out_illegal   <= 1'b0;
      out_pc        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_alusel    <= dec_alusel;
      out_a         <= op_a;
      out_b         <= op_b;
      out_rd        <= rd;
      out_reg_write <= legal && (rd != 5'd0);
      out_illegal   <= !legal;
      out_pc        <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : id_ex_stage
`default_nettype wire
